// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath: FSM encodings, fixed-point formats and the
// saturation constant.
package softmax_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StWaitLn,
    StStream,
    StDone
  } sm_state_e;

  localparam int unsigned Q4_28_FRAC = 28;
  localparam int unsigned Q2_30_FRAC = 30;

  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/diff_buffer.sv
// Register array holding one vector of (x_i - x_max) values.
// Synchronous write port and asynchronous read port.
module diff_buffer #(
  parameter int unsigned data_size = 32,
  parameter int unsigned num_elem  = 10,
  parameter int unsigned addr_size = 4
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [addr_size-1:0] waddr,
  input  logic [data_size-1:0] wdata,
  input  logic [addr_size-1:0] raddr,
  output logic [data_size-1:0] rdata
);

  logic [data_size-1:0] mem [num_elem];

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(num_elem); i++) begin
      if (we && (waddr == addr_size'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  // Decoded read keeps out-of-range addresses harmless when addr_size is wider than needed.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(num_elem); i++) begin
      if (raddr == addr_size'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/ln_sub_block.sv
// Log-domain normalisation: buffers one vector of differences, waits for ln(sum exp) and
// streams y_i = diff_i - ln over a valid/ready handshake.
module ln_sub_block
  import softmax_pkg::*;
#(
  parameter int unsigned data_size = 32,
  parameter int unsigned num_elem  = 10,
  parameter int unsigned addr_size = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] diff_data_i,
  input  logic                 diff_data_valid_i,
  input  logic [data_size-1:0] ln_data_i,
  input  logic                 ln_data_valid_i,
  output logic [data_size-1:0] sub_data_o,
  output logic                 sub_data_valid_o,
  input  logic                 sub_data_ready_i,
  output logic [addr_size-1:0] sub_index_o,
  output logic                 sub_last_o,
  output logic                 busy_o
);

  localparam int unsigned LnShift = Q2_30_FRAC - Q4_28_FRAC;
  localparam int unsigned LnW     = data_size - LnShift;
  localparam logic [addr_size-1:0] LastIdx = addr_size'(num_elem - 1);

  sm_state_e            state_q, state_d;
  logic [addr_size-1:0] wr_cnt_q, wr_cnt_d;
  logic [addr_size-1:0] rd_cnt_q, rd_cnt_d;
  logic [LnW-1:0]       ln_q, ln_d;
  logic                 ln_seen_q, ln_seen_d;
  logic [data_size-1:0] out_data_q, out_data_d;
  logic [addr_size-1:0] out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;
  logic                 out_valid_q, out_valid_d;

  logic                 buf_we;
  logic [data_size-1:0] buf_rdata;
  logic [data_size:0]   sub_wide;
  logic [data_size-1:0] sub_result;
  logic                 handshake;

  diff_buffer #(
    .data_size(data_size),
    .num_elem (num_elem),
    .addr_size(addr_size)
  ) u_diff_buffer (
    .clock(clock_i),
    .we   (buf_we),
    .waddr(wr_cnt_q),
    .wdata(diff_data_i),
    .raddr(rd_cnt_q),
    .rdata(buf_rdata)
  );

  // ln is stored already truncated to Q4.28; r below -2^31 clamps to the most negative value.
  always_comb begin
    sub_wide   = {buf_rdata[data_size-1], buf_rdata} - {1'b0, {LnShift{1'b0}}, ln_q};
    sub_result = (sub_wide[data_size] && !sub_wide[data_size-1]) ?
                 SAT_MIN[data_size-1:0] : sub_wide[data_size-1:0];
  end

  assign handshake = out_valid_q && sub_data_ready_i;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    ln_d        = ln_q;
    ln_seen_d   = ln_seen_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    buf_we      = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (ln_data_valid_i && !ln_seen_q) begin
          ln_d      = ln_data_i[data_size-1:LnShift];
          ln_seen_d = 1'b1;
        end
        if (diff_data_valid_i) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LastIdx) begin
            state_d = ln_seen_q ? StStream : StWaitLn;
          end
        end
      end
      StWaitLn: begin
        // ln_seen can already be set if ln arrived on the same edge as the last write.
        if (ln_seen_q) begin
          state_d = StStream;
        end else if (ln_data_valid_i) begin
          ln_d      = ln_data_i[data_size-1:LnShift];
          ln_seen_d = 1'b1;
          state_d   = StStream;
        end
      end
      StStream: begin
        if (handshake && out_last_q) begin
          state_d     = StDone;
          out_valid_d = 1'b0;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
        end else if (!out_valid_q || sub_data_ready_i) begin
          out_valid_d = 1'b1;
          out_data_d  = sub_result;
          out_idx_d   = rd_cnt_q;
          out_last_d  = (rd_cnt_q == LastIdx);
          rd_cnt_d    = rd_cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (!ln_data_valid_i) begin
          state_d   = StLoad;
          ln_seen_d = 1'b0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StLoad;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      ln_q        <= '0;
      ln_seen_q   <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      ln_q        <= ln_d;
      ln_seen_q   <= ln_seen_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sub_data_o       = out_data_q;
  assign sub_data_valid_o = out_valid_q;
  assign sub_index_o      = out_idx_q;
  assign sub_last_o       = out_last_q;
  assign busy_o           = (state_q != StLoad);

endmodule
